instr_fetch_sequencer: RTL and testbench

//  Sequences the 128-bit-line instruction memory and feeds decode one instruction per cycle.

---
 rtl/instr_fetch_sequencer.sv | 147 ++++++++++++++
 tb/tb_instr_fetch_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_sequencer.sv
// Instruction fetch sequencer: fetches a 128-bit line from instruction memory after a fixed
// settle window, then issues its four words to decode over valid/ready, with branch redirect.
module instr_fetch_sequencer #(
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter int                WAIT_CYCLES = 7
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              fetch_en_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [127:0]      mem_line_i,
    output logic [31:0]       instr_o,
    output logic [ADDR_W-1:0] instr_pc_o,
    output logic              instr_valid_o,
    input  logic              instr_ready_i,
    input  logic              redirect_valid_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic              fetching_o
);

    localparam int CNT_W = $clog2(WAIT_CYCLES + 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_FETCH   = 2'd1;
    localparam logic [1:0] ST_DELIVER = 2'd2;

    localparam logic [ADDR_W-1:0] WORD_MASK = ~(ADDR_W'(3));
    localparam logic [ADDR_W-5:0] LINE_ONE  = (ADDR_W-4)'(1);

    logic [1:0]        state_q,       state_d;
    logic [ADDR_W-1:0] pc_q,          pc_d;
    logic [CNT_W-1:0]  wait_cnt_q,    wait_cnt_d;
    logic [127:0]      buf_q,         buf_d;
    logic [1:0]        slot_q,        slot_d;
    logic [31:0]       instr_q,       instr_d;
    logic [ADDR_W-1:0] instr_pc_q,    instr_pc_d;
    logic              instr_valid_q, instr_valid_d;
    logic              fetching_q,    fetching_d;
    logic              transfer_s;

    function automatic logic [31:0] line_word(input logic [127:0] line, input logic [1:0] idx);
        logic [31:0] w;
        case (idx)
            2'd0:    w = line[31:0];
            2'd1:    w = line[63:32];
            2'd2:    w = line[95:64];
            2'd3:    w = line[127:96];
            default: w = 32'h0000_0000;
        endcase
        return w;
    endfunction

    assign transfer_s = instr_valid_q & instr_ready_i;

    // Next-state: redirect overrides everything; a same-edge transfer needs no extra work.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        wait_cnt_d    = wait_cnt_q;
        buf_d         = buf_q;
        slot_d        = slot_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        if (redirect_valid_i) begin
            pc_d          = redirect_pc_i & WORD_MASK;
            instr_valid_d = 1'b0;
            wait_cnt_d    = '0;
            state_d       = fetch_en_i ? ST_FETCH : ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (fetch_en_i) begin
                        state_d    = ST_FETCH;
                        wait_cnt_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_FETCH: begin
                    if (wait_cnt_q == CNT_W'(WAIT_CYCLES - 1)) begin
                        buf_d         = mem_line_i;
                        slot_d        = pc_q[3:2];
                        instr_d       = line_word(mem_line_i, pc_q[3:2]);
                        instr_pc_d    = pc_q;
                        instr_valid_d = 1'b1;
                        state_d       = ST_DELIVER;
                    end else begin
                        wait_cnt_d = wait_cnt_q + CNT_W'(1);
                    end
                end
                ST_DELIVER: begin
                    if (!transfer_s) begin
                        state_d = ST_DELIVER;
                    end else if (slot_q != 2'd3) begin
                        slot_d     = slot_q + 2'd1;
                        instr_d    = line_word(buf_q, slot_q + 2'd1);
                        instr_pc_d = {pc_q[ADDR_W-1:4], slot_q + 2'd1, pc_q[1:0]};
                    end else begin
                        pc_d          = {pc_q[ADDR_W-1:4] + LINE_ONE, 4'b0000};
                        instr_valid_d = 1'b0;
                        wait_cnt_d    = '0;
                        state_d       = fetch_en_i ? ST_FETCH : ST_IDLE;
                    end
                end
                default: begin
                    state_d       = ST_IDLE;
                    instr_valid_d = 1'b0;
                end
            endcase
        end
        fetching_d = (state_d == ST_FETCH);
    end

    // State and output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC & WORD_MASK;
            wait_cnt_q    <= '0;
            buf_q         <= 128'd0;
            slot_q        <= 2'd0;
            instr_q       <= 32'd0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            fetching_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            wait_cnt_q    <= wait_cnt_d;
            buf_q         <= buf_d;
            slot_q        <= slot_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            fetching_q    <= fetching_d;
        end
    end

    assign mem_addr_o    = {pc_q[ADDR_W-1:4], 4'b0000};
    assign instr_o       = instr_q;
    assign instr_pc_o    = instr_pc_q;
    assign instr_valid_o = instr_valid_q;
    assign fetching_o    = fetching_q;

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Directed bench for instr_fetch_sequencer with a combinational instruction-memory model.
module tb_instr_fetch_sequencer;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         fetch_en_i;
    logic [31:0]  mem_addr_o;
    logic [127:0] mem_line_i;
    logic [31:0]  instr_o;
    logic [31:0]  instr_pc_o;
    logic         instr_valid_o;
    logic         instr_ready_i;
    logic         redirect_valid_i;
    logic [31:0]  redirect_pc_i;
    logic         fetching_o;

    int n_total = 0;
    int n_pass  = 0;
    int n_edges;

    instr_fetch_sequencer #(.ADDR_W(32), .RESET_PC(32'h0), .WAIT_CYCLES(7)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .fetch_en_i       (fetch_en_i),
        .mem_addr_o       (mem_addr_o),
        .mem_line_i       (mem_line_i),
        .instr_o          (instr_o),
        .instr_pc_o       (instr_pc_o),
        .instr_valid_o    (instr_valid_o),
        .instr_ready_i    (instr_ready_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .fetching_o       (fetching_o)
    );

    always #5 clk_i = ~clk_i;

    // Line 0 holds the fixed program; every other word encodes its own address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        case (a)
            32'h0:   w = 32'h0043_0800;
            32'h4:   w = 32'h00A6_2001;
            32'h8:   w = 32'h0109_3802;
            32'hC:   w = 32'h016C_5003;
            default: w = {16'hC0DE, a[15:0]};
        endcase
        return w;
    endfunction

    always_comb begin
        mem_line_i = {mem_word(mem_addr_o + 32'd12), mem_word(mem_addr_o + 32'd8),
                      mem_word(mem_addr_o + 32'd4), mem_word(mem_addr_o)};
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!instr_valid_o && n < 40) begin
            step();
            n++;
        end
    endtask

    task automatic expect_instr(input string tag, input logic [31:0] pc);
        check({tag, "_valid"}, {63'd0, instr_valid_o}, 64'd1);
        check({tag, "_pc"}, {32'd0, instr_pc_o}, {32'd0, pc});
        check({tag, "_instr"}, {32'd0, instr_o}, {32'd0, mem_word(pc)});
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        #1;
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1; fetch_en_i = 1'b0; instr_ready_i = 1'b1;
        redirect_valid_i = 1'b0; redirect_pc_i = 32'h0;
        @(negedge clk_i);
        check("rst_valid", {63'd0, instr_valid_o}, 64'd0);
        check("rst_fetching", {63'd0, fetching_o}, 64'd0);
        check("rst_mem_addr", {32'd0, mem_addr_o}, 64'd0);
        check("rst_instr", {32'd0, instr_o}, 64'd0);
        check("rst_instr_pc", {32'd0, instr_pc_o}, 64'd0);

        // 1: first line, ready held high
        rst_i = 1'b0; fetch_en_i = 1'b1;
        step();
        check("t1_fetching", {63'd0, fetching_o}, 64'd1);
        wait_valid(n_edges);
        check("t1_latency", 64'(n_edges), 64'd7);
        expect_instr("t1_s0", 32'h0);
        step(); expect_instr("t1_s1", 32'h4);
        step(); expect_instr("t1_s2", 32'h8);
        step(); expect_instr("t1_s3", 32'hC);
        step();
        check("t1_end_valid", {63'd0, instr_valid_o}, 64'd0);
        check("t1_end_fetching", {63'd0, fetching_o}, 64'd1);
        check("t1_next_addr", {32'd0, mem_addr_o}, 64'h10);

        // 2: backpressure holds the current word
        wait_valid(n_edges);
        check("t2_latency", 64'(n_edges), 64'd7);
        expect_instr("t2_a", 32'h10);
        step(); expect_instr("t2_b", 32'h14);
        instr_ready_i = 1'b0;
        step(); expect_instr("t2_hold1", 32'h14);
        step(); expect_instr("t2_hold2", 32'h14);
        instr_ready_i = 1'b1;
        step(); expect_instr("t2_c", 32'h18);
        step(); expect_instr("t2_d", 32'h1C);
        step();
        check("t2_next_addr", {32'd0, mem_addr_o}, 64'h20);

        // 3: redirect mid-FETCH restarts the count, low address bits ignored
        do_reset();
        fetch_en_i = 1'b1;
        step(); step(); step();
        redirect_valid_i = 1'b1; redirect_pc_i = 32'h1B;
        step();
        redirect_valid_i = 1'b0;
        check("t3_mem_addr", {32'd0, mem_addr_o}, 64'h10);
        check("t3_fetching", {63'd0, fetching_o}, 64'd1);
        wait_valid(n_edges);
        check("t3_latency", 64'(n_edges), 64'd7);
        expect_instr("t3_a", 32'h18);
        step(); expect_instr("t3_b", 32'h1C);
        step();
        check("t3_next_addr", {32'd0, mem_addr_o}, 64'h20);
        check("t3_next_fetching", {63'd0, fetching_o}, 64'd1);

        // 4: redirect on the same edge as a transfer
        wait_valid(n_edges);
        expect_instr("t4_a", 32'h20);
        step(); expect_instr("t4_b", 32'h24);
        redirect_valid_i = 1'b1; redirect_pc_i = 32'h40;
        step();
        redirect_valid_i = 1'b0;
        check("t4_drop_valid", {63'd0, instr_valid_o}, 64'd0);
        wait_valid(n_edges);
        check("t4_latency", 64'(n_edges), 64'd7);
        expect_instr("t4_redir", 32'h40);

        // 5: fetch_en low mid-line finishes the line then idles
        fetch_en_i = 1'b0;
        step(); expect_instr("t5_a", 32'h44);
        step(); expect_instr("t5_b", 32'h48);
        step(); expect_instr("t5_c", 32'h4C);
        step();
        check("t5_idle_valid", {63'd0, instr_valid_o}, 64'd0);
        check("t5_idle_fetching", {63'd0, fetching_o}, 64'd0);
        step(); step();
        check("t5_still_idle", {63'd0, fetching_o}, 64'd0);
        check("t5_idle_addr", {32'd0, mem_addr_o}, 64'h50);
        fetch_en_i = 1'b1;
        step();
        check("t5_resume", {63'd0, fetching_o}, 64'd1);
        wait_valid(n_edges);
        check("t5_latency", 64'(n_edges), 64'd7);
        expect_instr("t5_resume", 32'h50);

        // 6: asynchronous reset mid-FETCH and mid-DELIVER
        step(); step(); step(); step();
        step(); step();
        check("t6_in_fetch", {63'd0, fetching_o}, 64'd1);
        #1 rst_i = 1'b1;
        #1;
        check("t6f_fetching", {63'd0, fetching_o}, 64'd0);
        check("t6f_mem_addr", {32'd0, mem_addr_o}, 64'h0);
        check("t6f_valid", {63'd0, instr_valid_o}, 64'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        wait_valid(n_edges);
        check("t6_restart_latency", 64'(n_edges), 64'd8);
        expect_instr("t6_restart", 32'h0);
        instr_ready_i = 1'b0;
        #1 rst_i = 1'b1;
        #1;
        check("t6d_valid", {63'd0, instr_valid_o}, 64'd0);
        check("t6d_instr", {32'd0, instr_o}, 64'd0);
        check("t6d_instr_pc", {32'd0, instr_pc_o}, 64'd0);
        check("t6d_mem_addr", {32'd0, mem_addr_o}, 64'h0);
        @(negedge clk_i);
        rst_i = 1'b0; instr_ready_i = 1'b1;
        wait_valid(n_edges);
        check("t6d_restart_latency", 64'(n_edges), 64'd8);
        expect_instr("t6d_restart", 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
